uart_rx_deserializer: RTL and testbench

Receive front end of the UART: synchronizes the asynchronous `RxD` pin, recovers 8N1 frames using 16x oversampling, and presents each received byte in a one-entry holding register. It sits directly upstream of the UART register block, which reads `rx_data` for its Rx-data register (address 1) and returns `rd_ack` when the CPU reads it. Frame errors and overruns are reported as status flags for that block.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_rx_deserializer.sv | 136 +++++++++++++
 tb/tb_uart_rx_deserializer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default line settings and
// the oversampling divisor used by both the receiver and the transmitter.
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ  = 100_000_000;
    localparam int unsigned DEF_BAUD      = 9600;
    localparam int unsigned DEF_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Clocks per oversample tick; integer truncation (651 at the defaults).
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle pulse every DIV clocks.
// Never realigned to line activity, so it is shareable between RX and TX.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD       = DEF_BAUD,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic pClk,
    input  logic pReset,
    output logic tick
);

    localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge pClk) begin
        if (pReset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: RxD synchronizer, 16x-oversampled 8N1 frame
// recovery and a one-entry holding register with frame-error/overrun flags.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD       = DEF_BAUD,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic       pClk,
    input  logic       pReset,
    input  logic       RxD,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr,
    output logic       rx_overrun,
    output logic       rx_busy,
    output rx_state_t  fsm_state
);

    logic      tick;
    logic      rx_meta, rx_s;
    rx_state_t state, state_nxt;
    logic [3:0] scnt, scnt_nxt;
    logic [2:0] bcnt, bcnt_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic       done;

    uart_baud_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .pClk   (pClk),
        .pReset (pReset),
        .tick   (tick)
    );

    // Both stages reset to the idle line level so reset never fakes a start.
    always_ff @(posedge pClk) begin
        if (pReset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge pClk) begin
        if (pReset) begin
            state <= IDLE;
            scnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            scnt  <= scnt_nxt;
            bcnt  <= bcnt_nxt;
            shreg <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        scnt_nxt  = scnt;
        bcnt_nxt  = bcnt;
        shreg_nxt = shreg;
        done      = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nxt = START;
                        scnt_nxt  = '0;
                    end
                end
                START: begin
                    if (scnt == 4'd7) begin
                        scnt_nxt  = '0;
                        bcnt_nxt  = '0;
                        state_nxt = rx_s ? IDLE : DATA;
                    end else begin
                        scnt_nxt = scnt + 4'd1;
                    end
                end
                DATA: begin
                    scnt_nxt = scnt + 4'd1;
                    if (scnt == 4'd15) begin
                        shreg_nxt = {rx_s, shreg[7:1]};
                        bcnt_nxt  = bcnt + 3'd1;
                        if (bcnt == 3'd7) begin
                            state_nxt = STOP;
                        end
                    end
                end
                STOP: begin
                    scnt_nxt = scnt + 4'd1;
                    // Leave at the stop midpoint so a back-to-back start is caught.
                    if (scnt == 4'd15) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge pClk) begin
        if (pReset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_ferr    <= 1'b0;
            rx_overrun <= 1'b0;
        end else if (done) begin
            if (!rx_valid || rd_ack) begin
                rx_data    <= shreg;
                rx_valid   <= 1'b1;
                rx_ferr    <= ~rx_s;
                rx_overrun <= 1'b0;
            end else begin
                rx_overrun <= 1'b1;
            end
        end else if (rd_ack) begin
            rx_valid   <= 1'b0;
            rx_ferr    <= 1'b0;
            rx_overrun <= 1'b0;
        end
    end

    assign rx_busy   = (state != IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed frames from the test plan plus
// random frames, checked against a holding-register model of the receiver.
module tb_uart_rx_deserializer;

    // Line rate scaled up so whole frames fit in a short run; 16 ticks of DIV clocks per bit.
    localparam int unsigned CLK_FREQ = 100_000_000;
    localparam int unsigned BAUD     = 1_000_000;
    localparam int unsigned OVS      = 16;
    localparam int unsigned DIV      = CLK_FREQ / (BAUD * OVS);
    localparam int unsigned BIT_CYC  = DIV * OVS;

    logic       pClk;
    logic       pReset;
    logic       RxD;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;
    logic       rx_overrun;
    logic       rx_busy;
    logic [1:0] fsm_state;

    uart_rx_deserializer #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVS)
    ) dut (
        .pClk       (pClk),
        .pReset     (pReset),
        .RxD        (RxD),
        .rd_ack     (rd_ack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ferr    (rx_ferr),
        .rx_overrun (rx_overrun),
        .rx_busy    (rx_busy),
        .fsm_state  (fsm_state)
    );

    // clock / watchdog
    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    initial begin
        repeat (80000) @(posedge pClk);
        $display("FAIL watchdog: run exceeded 80000 cycles");
        $fatal(1, "watchdog expired");
    end

    int busy_cycles = 0;
    always @(negedge pClk) if (rx_busy === 1'b1) busy_cycles++;

    // reference model of the holding register
    logic [7:0] m_data;
    logic       m_valid, m_ferr, m_ovr;
    int         checks   = 0;
    int         failures = 0;

    task automatic model_reset();
        m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop, input logic ack_same);
        if (!m_valid || ack_same) begin
            m_data = b; m_valid = 1'b1; m_ferr = ~stop; m_ovr = 1'b0;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check_byte({tag, "/data"},  rx_data,    m_data);
        check_bit ({tag, "/valid"}, rx_valid,   m_valid);
        check_bit ({tag, "/ferr"},  rx_ferr,    m_ferr);
        check_bit ({tag, "/ovr"},   rx_overrun, m_ovr);
    endtask

    // driver tasks (all called on a falling clock edge)
    task automatic idle_bits(input int n);
        repeat (n * BIT_CYC) @(negedge pClk);
    endtask

    task automatic send_line(input logic [7:0] b, input logic stop);
        RxD = 1'b0;
        repeat (BIT_CYC) @(negedge pClk);
        for (int i = 0; i < 8; i++) begin
            RxD = b[i];
            repeat (BIT_CYC) @(negedge pClk);
        end
        RxD = stop;
        repeat (BIT_CYC) @(negedge pClk);
        RxD = 1'b1;
    endtask

    task automatic ack_pulse();
        rd_ack = 1'b1;
        @(negedge pClk);
        rd_ack = 1'b0;
        m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    endtask

    logic [7:0] rbyte, abyte;
    logic       rstop;
    int         waited, busy_before;

    initial begin
        pReset = 1'b1;
        RxD    = 1'b1;
        rd_ack = 1'b0;
        model_reset();
        repeat (3) @(negedge pClk);
        pReset = 1'b0;
        check_model("reset");
        check_bit("reset/busy", rx_busy, 1'b0);
        idle_bits(1);

        // single byte, then consume it
        send_line(8'h14, 1'b1); model_frame(8'h14, 1'b1, 1'b0);
        check_model("byte14");
        check_bit("byte14/busy", rx_busy, 1'b0);
        ack_pulse();
        check_model("byte14_ack");

        // back-to-back without a read: second byte overruns
        send_line(8'h55, 1'b1); model_frame(8'h55, 1'b1, 1'b0);
        send_line(8'hA3, 1'b1); model_frame(8'hA3, 1'b1, 1'b0);
        check_model("overrun");
        ack_pulse();
        check_model("overrun_ack");

        // stop bit driven low: byte kept, frame error flagged
        send_line(8'hFF, 1'b0); model_frame(8'hFF, 1'b0, 1'b0);
        check_model("ferr");
        idle_bits(2);
        ack_pulse();
        check_model("ferr_ack");
        idle_bits(1);

        // short low glitch: false start lasts exactly the 8 ticks up to the start mid-sample
        busy_before = busy_cycles;
        RxD = 1'b0;
        repeat (3 * DIV) @(negedge pClk);
        RxD = 1'b1;
        repeat (16 * DIV) @(negedge pClk);
        check_int("glitch/busy_len", busy_cycles - busy_before, int'(8 * DIV));
        check_bit("glitch/busy", rx_busy, 1'b0);
        check_model("glitch");
        idle_bits(1);

        // reset in bit 4 of 0x3C with a byte already held
        rbyte = 8'($urandom_range(0, 255));
        send_line(rbyte, 1'b1); model_frame(rbyte, 1'b1, 1'b0);
        check_model("pre_reset");
        fork
            send_line(8'h3C, 1'b1);
            begin
                repeat (5 * BIT_CYC + BIT_CYC / 2) @(negedge pClk);
                pReset = 1'b1;
                @(negedge pClk);
                pReset = 1'b0;
                model_reset();
                check_model("mid_reset");
                check_bit("mid_reset/busy", rx_busy, 1'b0);
            end
        join
        // the falling edge into bit 6 after reset starts a fresh frame: 0,1,1,... -> 0xFE
        idle_bits(8);
        model_frame(8'hFE, 1'b1, 1'b0);
        check_model("resync");
        ack_pulse();
        send_line(8'h81, 1'b1); model_frame(8'h81, 1'b1, 1'b0);
        check_model("after_reset");
        ack_pulse();
        idle_bits(1);

        // read acknowledged in the very cycle the second byte completes
        abyte = 8'($urandom_range(0, 255));
        send_line(abyte, 1'b1); model_frame(abyte, 1'b1, 1'b0);
        check_model("first_held");
        fork
            send_line(8'h7E, 1'b1);
            begin
                waited = 0;
                while (fsm_state !== 2'd3 && waited < int'(12 * BIT_CYC)) begin
                    @(negedge pClk);
                    waited++;
                end
                check_bit("reach_stop", (fsm_state === 2'd3), 1'b1);
                if (fsm_state === 2'd3) begin
                    repeat (BIT_CYC - 1) @(negedge pClk);
                    check_byte("pre_done/data", rx_data, abyte);
                    check_bit("pre_done/valid", rx_valid, 1'b1);
                    rd_ack = 1'b1;
                    @(negedge pClk);
                    rd_ack = 1'b0;
                end
            end
        join
        model_frame(8'h7E, 1'b1, 1'b1);
        check_model("same_cycle_ack");
        ack_pulse();
        idle_bits(1);

        // random frames, random stop bits, random reads
        for (int n = 0; n < 8; n++) begin
            rbyte = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 3) != 0);
            send_line(rbyte, rstop); model_frame(rbyte, rstop, 1'b0);
            check_model($sformatf("rand%0d", n));
            if (!rstop) idle_bits(2);
            if ($urandom_range(0, 1) == 1) begin
                ack_pulse();
                check_model($sformatf("rand%0d_ack", n));
            end
            if ($urandom_range(0, 1) == 1) idle_bits(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
